// File: rtl/cpu_sequencer.sv
// Multicycle fetch/decode/execute/memory/writeback sequencer sharing one RAM port.
// Define SEQ_RETIRE_CNT_EN to build the retired-instruction counter; otherwise retired reads 0.
module cpu_sequencer #(
  parameter int DEC_LAT     = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [2:0]  alu_func,
  input  logic        ram_load,
  input  logic        ram_write,
  input  logic        jump,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel,
  output logic        ir_load,
  output logic        alu_en,
  output logic        reg_we,
  output logic        pc_en,
  output logic        pc_jump,
  output logic        busy,
  output logic        fault,
  output logic [2:0]  state,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_NEXT   = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_NOP   = 3'd0,
    C_ALU   = 3'd1,
    C_LOAD  = 3'd2,
    C_STORE = 3'd3,
    C_JUMP  = 3'd4
  } cls_t;

  localparam logic [2:0] DEC_LAST = 3'(DEC_LAT - 1);
  localparam logic [7:0] TMO      = 8'(MEM_TIMEOUT);

  state_t      state_reg;
  cls_t        cls_reg;
  logic [7:0]  wait_reg;
  logic [2:0]  dec_reg;
  logic        fault_reg;

  logic        is_alu;
  logic [2:0]  n_strobes;
  logic        timed_out;

  assign is_alu    = |alu_func;
  assign n_strobes = 3'(is_alu) + 3'(ram_load) + 3'(ram_write) + 3'(jump);
  // This is the last permitted unacknowledged cycle; an ack in it still wins.
  assign timed_out = (TMO != 8'd0) && (wait_reg == TMO - 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cls_reg   <= C_NOP;
      wait_reg  <= '0;
      dec_reg   <= '0;
      fault_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (run) begin
            state_reg <= S_FETCH;
            wait_reg  <= '0;
          end
        end
        S_FETCH: begin
          if (mem_ack) begin
            state_reg <= S_DECODE;
            dec_reg   <= '0;
            wait_reg  <= '0;
          end else if (timed_out) begin
            state_reg <= S_HALT;
            fault_reg <= 1'b1;
          end else begin
            wait_reg <= wait_reg + 8'd1;
          end
        end
        S_DECODE: begin
          if (dec_reg != DEC_LAST) begin
            dec_reg <= dec_reg + 3'd1;
          end else if (n_strobes > 3'd1) begin
            state_reg <= S_HALT;
            fault_reg <= 1'b1;
          end else if (is_alu) begin
            cls_reg   <= C_ALU;
            state_reg <= S_EXEC;
          end else if (ram_load || ram_write) begin
            cls_reg   <= ram_load ? C_LOAD : C_STORE;
            state_reg <= S_MEM;
            wait_reg  <= '0;
          end else begin
            cls_reg   <= jump ? C_JUMP : C_NOP;
            state_reg <= S_NEXT;
          end
        end
        S_EXEC: state_reg <= S_WB;
        S_MEM: begin
          if (mem_ack) begin
            state_reg <= (cls_reg == C_STORE) ? S_NEXT : S_WB;
            wait_reg  <= '0;
          end else if (timed_out) begin
            state_reg <= S_HALT;
            fault_reg <= 1'b1;
          end else begin
            wait_reg <= wait_reg + 8'd1;
          end
        end
        S_WB: state_reg <= S_NEXT;
        S_NEXT: begin
          state_reg <= run ? S_FETCH : S_IDLE;
          wait_reg  <= '0;
        end
        S_HALT:  state_reg <= S_HALT;
        default: state_reg <= S_HALT;
      endcase
    end
  end

  // Everything but ir_load is a pure decode of registered state.
  assign mem_req = (state_reg == S_FETCH) || (state_reg == S_MEM);
  assign mem_sel = (state_reg == S_MEM);
  assign mem_we  = (state_reg == S_MEM) && (cls_reg == C_STORE);
  assign ir_load = (state_reg == S_FETCH) && mem_ack;
  assign alu_en  = (state_reg == S_EXEC);
  assign reg_we  = (state_reg == S_WB);
  assign pc_en   = (state_reg == S_NEXT);
  assign pc_jump = (state_reg == S_NEXT) && (cls_reg == C_JUMP);
  assign busy    = (state_reg != S_IDLE) && (state_reg != S_HALT);
  assign fault   = fault_reg;
  assign state   = state_reg;

`ifdef SEQ_RETIRE_CNT_EN
  logic [31:0] retired_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_reg <= '0;
    end else if (state_reg == S_NEXT) begin
      retired_reg <= retired_reg + 32'd1;
    end
  end

  assign retired = retired_reg;
`else
  assign retired = '0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: a per-instruction cycle model builds the expected output stream,
// one loop drives inputs and compares every cycle, plus literal latency and length checks.
module tb_cpu_sequencer;
  localparam int DEC_LAT = 2;
  localparam int TMO     = 15;

  localparam logic [7:0] O_REQ = 8'h80;
  localparam logic [7:0] O_WE  = 8'h40;
  localparam logic [7:0] O_SEL = 8'h20;
  localparam logic [7:0] O_IRL = 8'h10;
  localparam logic [7:0] O_ALU = 8'h08;
  localparam logic [7:0] O_RW  = 8'h04;
  localparam logic [7:0] O_PCE = 8'h02;
  localparam logic [7:0] O_PCJ = 8'h01;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [2:0]  alu_func = 3'd0;
  logic        ram_load = 1'b0;
  logic        ram_write = 1'b0;
  logic        jump = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, mem_sel, ir_load, alu_en, reg_we;
  logic        pc_en, pc_jump, busy, fault;
  logic [2:0]  state;
  logic [31:0] retired;

  cpu_sequencer #(.DEC_LAT(DEC_LAT), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .alu_func(alu_func),
    .ram_load(ram_load), .ram_write(ram_write), .jump(jump), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .ir_load(ir_load),
    .alu_en(alu_en), .reg_we(reg_we), .pc_en(pc_en), .pc_jump(pc_jump),
    .busy(busy), .fault(fault), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        run;
    logic [5:0]  dec;   // {alu_func, ram_load, ram_write, jump}
    logic        ack;
    logic [12:0] exp;   // {state, 8 strobes, busy, fault}
    logic [31:0] ret;
  } cyc_t;

  cyc_t        q[$];
  int          total = 0;
  int          passed = 0;
  int          cyc = 0;
  logic [31:0] m_ret = 0;
  bit          m_fault = 0;
  bit          m_halt = 0;
  int          first_irl, first_alu, first_rw, first_pce;

  function automatic logic [5:0] rdec();
    return 6'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  function automatic void add(input int st, input logic [7:0] o, input logic ack,
                              input logic run_v, input logic [5:0] dec);
    cyc_t c;
    c.run = run_v;
    c.dec = dec;
    c.ack = ack;
    c.exp = {3'(st), o, 1'(st != 0 && st != 7), m_fault};
    c.ret = m_ret;
    q.push_back(c);
  endfunction

  // A RAM access held for w unacknowledged cycles; returns 0 when it times out.
  function automatic bit access(input int st, input logic [7:0] o, input int w,
                                input logic [7:0] o_ack, inout int len);
    int k;
    k = (TMO > 0 && w >= TMO) ? TMO : w;
    for (int i = 0; i < k; i++) begin
      add(st, o, 1'b0, rbit(), rdec());
      len++;
    end
    if (TMO > 0 && w >= TMO) begin
      m_fault = 1;
      m_halt  = 1;
      return 0;
    end
    add(st, o | o_ack, 1'b1, rbit(), rdec());
    len++;
    return 1;
  endfunction

  // Expected cycles of one instruction from FETCH through NEXT (or until it halts).
  function automatic int gen(input logic [5:0] dec, input int fw, input int mw,
                             input logic run_after);
    int len;
    int n;
    bit is_alu, is_ld, is_sw, is_jp;
    len    = 0;
    is_alu = (dec[5:3] != 3'd0);
    is_ld  = dec[2];
    is_sw  = dec[1];
    is_jp  = dec[0];
    n = int'(is_alu) + int'(is_ld) + int'(is_sw) + int'(is_jp);
    if (!access(1, O_REQ, fw, O_IRL, len)) return len;
    for (int d = 0; d < DEC_LAT; d++) begin
      add(2, 8'h00, rbit(), rbit(), dec);
      len++;
    end
    if (n > 1) begin
      m_fault = 1;
      m_halt  = 1;
      return len;
    end
    if (is_alu) begin
      add(3, O_ALU, rbit(), rbit(), rdec());
      len++;
    end
    if (is_ld || is_sw) begin
      if (!access(4, O_REQ | O_SEL | (is_sw ? O_WE : 8'h00), mw, 8'h00, len)) return len;
    end
    if (is_alu || is_ld) begin
      add(5, O_RW, rbit(), rbit(), rdec());
      len++;
    end
    add(6, O_PCE | (is_jp ? O_PCJ : 8'h00), rbit(), run_after, rdec());
    len++;
`ifdef SEQ_RETIRE_CNT_EN
    m_ret = m_ret + 32'd1;
`endif
    if (!run_after) begin
      int idle_n;
      idle_n = $urandom_range(0, 2);
      for (int i = 0; i < idle_n; i++) add(0, 8'h00, rbit(), 1'b0, rdec());
      add(0, 8'h00, rbit(), 1'b1, rdec());
    end
    return len;
  endfunction

  function automatic void halt_tail(input int n);
    for (int i = 0; i < n; i++) add(7, 8'h00, rbit(), rbit(), rdec());
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", name, got, exp);
  endtask

  task automatic run_q(input int maxn);
    cyc_t c;
    logic [12:0] got;
    int n;
    n = 0;
    while (q.size() > 0 && n < maxn) begin
      c = q.pop_front();
      run = c.run;
      {alu_func, ram_load, ram_write, jump} = c.dec;
      mem_ack = c.ack;
      @(negedge clk);
      got = {state, mem_req, mem_we, mem_sel, ir_load, alu_en, reg_we, pc_en, pc_jump,
             busy, fault};
      chk($sformatf("cyc%0d outputs", cyc), 64'(got), 64'(c.exp));
      chk($sformatf("cyc%0d retired", cyc), 64'(retired), 64'(c.ret));
      if (ir_load && first_irl < 0) first_irl = cyc;
      if (alu_en && first_alu < 0) first_alu = cyc;
      if (reg_we && first_rw < 0) first_rw = cyc;
      if (pc_en && first_pce < 0) first_pce = cyc;
      @(posedge clk);
      #1;
      n++;
      cyc++;
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_fault = 0;
    m_halt  = 0;
    m_ret   = 0;
    cyc     = 0;
    first_irl = -1;
    first_alu = -1;
    first_rw  = -1;
    first_pce = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    alu_func = 3'd0;
    ram_load = 1'b0;
    ram_write = 1'b0;
    jump = 1'b0;
    mem_ack = 1'b0;
    @(posedge clk);
    #3;
    chk("reset outputs", 64'({state, mem_req, mem_we, mem_sel, ir_load, alu_en, reg_we,
                              pc_en, pc_jump, busy, fault, retired}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int len;
    logic [5:0] dec;
    int fw, mw;
    logic ra;

    // Directed: add from reset with an always-ready RAM, then lw/sw with 3 wait cycles.
    do_reset();
    add(0, 8'h00, 1'b1, 1'b1, 6'd0);
    len = gen(6'b001_000, 0, 0, 1'b1);
    chk("alu length", 64'(len), 64'd6);
    run_q(100);
    chk("ir_load cycle", 64'(first_irl), 64'd1);
    chk("alu_en cycle", 64'(first_alu), 64'd4);
    chk("reg_we cycle", 64'(first_rw), 64'd5);
    chk("pc_en cycle", 64'(first_pce), 64'd6);
    len = gen(6'b000_100, 0, 3, 1'b1);
    chk("lw length", 64'(len), 64'd9);
    len = gen(6'b000_010, 0, 3, 1'b1);
    chk("sw length", 64'(len), 64'd8);
    len = gen(6'b000_001, 0, 0, 1'b1);
    chk("jump length", 64'(len), 64'd4);
    len = gen(6'b000_000, 0, 0, 1'b0);
    chk("nop length", 64'(len), 64'd4);
    len = gen(6'b000_000, TMO - 1, 0, 1'b1);
    chk("late ack length", 64'(len), 64'(TMO + 3));
    len = gen(6'b000_100, 0, TMO, 1'b1);
    chk("mem timeout length", 64'(len), 64'(TMO + 3));
    halt_tail(6);
    run_q(1000);
    $display("directed: add/lw/sw/jump/nop, late ack, mem timeout");

    // Fetch never acknowledged.
    do_reset();
    add(0, 8'h00, 1'b0, 1'b1, 6'd0);
    len = gen(rdec(), 1000, 0, 1'b1);
    chk("fetch timeout length", 64'(len), 64'(TMO));
    halt_tail(8);
    run_q(1000);
    $display("directed: fetch timeout");

    // lw and jump together.
    do_reset();
    add(0, 8'h00, 1'b0, 1'b1, 6'd0);
    len = gen(6'b000_101, 0, 0, 1'b1);
    chk("conflict length", 64'(len), 64'(1 + DEC_LAT));
    halt_tail(4);
    run_q(1000);
    $display("directed: conflicting decode");

    // Randomized instruction streams.
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      add(0, 8'h00, rbit(), 1'b1, rdec());
      for (int i = 0; i < 40 && !m_halt; i++) begin
        case ($urandom_range(0, 9))
          0, 1, 2: dec = {3'($urandom_range(1, 7)), 3'b000};
          3, 4:    dec = 6'b000_100;
          5:       dec = 6'b000_010;
          6:       dec = 6'b000_001;
          7:       dec = 6'b000_000;
          default: dec = rdec();
        endcase
        fw = ($urandom_range(0, 19) == 0) ? $urandom_range(TMO - 1, TMO + 3) : $urandom_range(0, 4);
        mw = ($urandom_range(0, 19) == 0) ? $urandom_range(TMO - 1, TMO + 3) : $urandom_range(0, 4);
        ra = ($urandom_range(0, 3) != 0);
        len = gen(dec, fw, mw, ra);
        $display("seg %0d instr %0d dec=%b fw=%0d mw=%0d run=%0b cycles=%0d halted=%0d",
                 seg, i, dec, fw, mw, ra, len, m_halt);
      end
      if (m_halt) halt_tail(5);
      run_q(5000);
    end

    // Asynchronous reset in the middle of a data access.
    do_reset();
    add(0, 8'h00, 1'b0, 1'b1, 6'd0);
    void'(gen(6'b000_100, 0, 6, 1'b1));
    run_q(6);
    mem_ack = 1'b0;
    #2;
    chk("mem_req before reset", 64'(mem_req), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mem_req async reset", 64'(mem_req), 64'd0);
    chk("state async reset", 64'(state), 64'd0);
    chk("busy async reset", 64'(busy), 64'd0);
    run = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) add(0, 8'h00, rbit(), 1'b0, rdec());
    run_q(100);
    $display("directed: reset during memory access");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
